// File: rtl/print_pkg.sv
// Shared definitions for the print arbiter: FSM state encoding, default
// character width, idle-counter width and requester-index width.
package print_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } state_t;

   localparam int unsigned DATA_WID_DEF = 8;
   localparam int unsigned TMO_CNT_W    = 8;
   localparam int unsigned ID_W         = 3;

endpackage

// File: rtl/print_arb_rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req     - request vector, one bit per requester
//   last_id - previously locked requester; search starts one above it and wraps
//   win_id  - index of the first requesting bit found
//   any     - at least one request is present
module rr_pick
   import print_pkg::*;
#(
   parameter int unsigned NREQ = 4
) (
   input  logic [NREQ-1:0] req,
   input  logic [ID_W-1:0] last_id,
   output logic [ID_W-1:0] win_id,
   output logic            any
);

   // Step k = 1..NREQ visits (last_id + k) mod NREQ; the first requester hit wins.
   always_comb begin
      win_id = '0;
      any    = 1'b0;
      for (int k = 1; k <= int'(NREQ); k++) begin
         for (int j = 0; j < int'(NREQ); j++) begin
            if (!any && req[j] &&
                ((int'(last_id) + k == j) || (int'(last_id) + k == j + int'(NREQ)))) begin
               any    = 1'b1;
               win_id = ID_W'(j);
            end
         end
      end
   end

endmodule

// File: rtl/print_arb.sv
// Print arbiter: locks one requester at a time onto a shared character FIFO
// until it sends an end-of-message character or stays idle for TMO_CYC cycles.
// Ports:
//   clk, nrst  - clock, async active-low reset
//   req_valid  - per-requester character available
//   req_data   - per-requester character, requester i at [i*DATA_WID +: DATA_WID]
//   req_last   - per-requester end-of-message flag
//   req_ready  - per-requester accept (only the locked requester, when FIFO not full)
//   fifo_push  - FIFO push strobe
//   fifo_data  - character to the FIFO
//   fifo_full  - FIFO full flag
//   busy       - a requester holds the lock
//   grant_id   - index of the locked requester (holds when idle)
//   tmo_err    - one-cycle pulse when a lock is released by timeout
module print_arb
   import print_pkg::*;
#(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned DATA_WID = DATA_WID_DEF,
   parameter int unsigned TMO_CYC  = 255
) (
   input  logic                     clk,
   input  logic                     nrst,
   input  logic [NREQ-1:0]          req_valid,
   input  logic [NREQ*DATA_WID-1:0] req_data,
   input  logic [NREQ-1:0]          req_last,
   output logic [NREQ-1:0]          req_ready,
   output logic                     fifo_push,
   output logic [DATA_WID-1:0]      fifo_data,
   input  logic                     fifo_full,
   output logic                     busy,
   output logic [ID_W-1:0]          grant_id,
   output logic                     tmo_err
);

   localparam logic [ID_W-1:0]      LAST_RST = ID_W'(NREQ - 1);
   localparam logic [TMO_CNT_W-1:0] TMO_LIM  = TMO_CNT_W'(TMO_CYC);

   state_t                 state;
   state_t                 state_nxt;
   logic [ID_W-1:0]        grant_nxt;
   logic [ID_W-1:0]        last_id;
   logic [ID_W-1:0]        last_nxt;
   logic [TMO_CNT_W-1:0]   idle_cnt;
   logic [TMO_CNT_W-1:0]   cnt_nxt;

   logic                   sel_valid;
   logic                   sel_last;
   logic [DATA_WID-1:0]    sel_data;
   logic [ID_W-1:0]        pick_id;
   logic                   pick_any;
   logic                   xfer;

   rr_pick #(
      .NREQ (NREQ)
   ) u_rr_pick (
      .req     (req_valid),
      .last_id (last_id),
      .win_id  (pick_id),
      .any     (pick_any)
   );

   // Mux the locked requester's lane.
   always_comb begin
      sel_valid = 1'b0;
      sel_last  = 1'b0;
      sel_data  = '0;
      for (int i = 0; i < int'(NREQ); i++) begin
         if (grant_id == ID_W'(i)) begin
            sel_valid = req_valid[i];
            sel_last  = req_last[i];
            sel_data  = req_data[i*DATA_WID +: DATA_WID];
         end
      end
   end

   // State and lock bookkeeping registers.
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state    <= IDLE;
         grant_id <= '0;
         last_id  <= LAST_RST;
         idle_cnt <= '0;
      end else begin
         state    <= state_nxt;
         grant_id <= grant_nxt;
         last_id  <= last_nxt;
         idle_cnt <= cnt_nxt;
      end
   end

   // Next-state and lane-steering outputs.
   always_comb begin
      state_nxt = state;
      grant_nxt = grant_id;
      last_nxt  = last_id;
      cnt_nxt   = idle_cnt;
      req_ready = '0;
      fifo_push = 1'b0;
      tmo_err   = 1'b0;
      xfer      = 1'b0;
      fifo_data = sel_data;

      case (state)
         IDLE: begin
            if (pick_any) begin
               grant_nxt = pick_id;
               cnt_nxt   = '0;
               state_nxt = LOCK;
            end
         end
         LOCK: begin
            for (int i = 0; i < int'(NREQ); i++) begin
               if (grant_id == ID_W'(i)) begin
                  req_ready[i] = !fifo_full;
               end
            end
            fifo_push = sel_valid && !fifo_full;
            xfer      = fifo_push;

            // Stall cycles with valid high are not idle.
            if (xfer) begin
               cnt_nxt = '0;
            end else if (!sel_valid) begin
               cnt_nxt = idle_cnt + TMO_CNT_W'(1);
            end

            // A last transfer wins over a coincident timeout.
            if (xfer && sel_last) begin
               last_nxt  = grant_id;
               state_nxt = IDLE;
            end else if (idle_cnt == TMO_LIM) begin
               tmo_err   = 1'b1;
               last_nxt  = grant_id;
               cnt_nxt   = '0;
               state_nxt = IDLE;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   assign busy = (state == LOCK);

endmodule

// File: tb/tb_print_arb.sv
// Directed self-checking bench for print_arb (NREQ=4, DATA_WID=8, TMO_CYC=10).
module tb_print_arb;

   logic        clk;
   logic        nrst;
   logic [3:0]  req_valid;
   logic [31:0] req_data;
   logic [3:0]  req_last;
   logic [3:0]  req_ready;
   logic        fifo_push;
   logic [7:0]  fifo_data;
   logic        fifo_full;
   logic        busy;
   logic [2:0]  grant_id;
   logic        tmo_err;

   int          n_chk;
   int          n_err;
   int          cyc;
   int          push_when_full;
   int          tmo_cnt;
   int          tmo_at;
   int          t0;
   logic        full;
   logic [3:0]  xfer_f;
   logic [8:0]  srcq [4][$];
   logic [7:0]  got [$];

   print_arb #(
      .NREQ     (4),
      .DATA_WID (8),
      .TMO_CYC  (10)
   ) dut (
      .clk       (clk),
      .nrst      (nrst),
      .req_valid (req_valid),
      .req_data  (req_data),
      .req_last  (req_last),
      .req_ready (req_ready),
      .fifo_push (fifo_push),
      .fifo_data (fifo_data),
      .fifo_full (fifo_full),
      .busy      (busy),
      .grant_id  (grant_id),
      .tmo_err   (tmo_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Negedge: retire last cycle's transfers, then present queue heads.
   task automatic drive_cyc();
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 4; i++) begin
         if (xfer_f[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
         xfer_f[i] = 1'b0;
         if (srcq[i].size() > 0) begin
            req_valid[i]      = 1'b1;
            req_data[i*8 +: 8] = srcq[i][0][7:0];
            req_last[i]       = srcq[i][0][8];
         end else begin
            req_valid[i]      = 1'b0;
            req_data[i*8 +: 8] = 8'h00;
            req_last[i]       = 1'b0;
         end
      end
      fifo_full = full;
   endtask

   // Just before the posedge: note handshakes, pushes and timeouts.
   task automatic sample_cyc();
      for (int i = 0; i < 4; i++) xfer_f[i] = req_valid[i] && req_ready[i];
      if (fifo_push) begin
         got.push_back(fifo_data);
         if (fifo_full) push_when_full++;
      end
      if (tmo_err) begin
         tmo_cnt++;
         tmo_at = cyc;
      end
   endtask

   task automatic cycle();
      drive_cyc();
      #4;
      sample_cyc();
   endtask

   task automatic do_reset();
      @(negedge clk);
      nrst = 1'b0;
      full = 1'b0;
      fifo_full = 1'b0;
      req_valid = '0;
      req_data  = '0;
      req_last  = '0;
      xfer_f    = '0;
      for (int i = 0; i < 4; i++) srcq[i].delete();
      got.delete();
      push_when_full = 0;
      tmo_cnt = 0;
      tmo_at  = 0;
      @(negedge clk);
      nrst = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0; n_err = 0; cyc = 0;
      push_when_full = 0; tmo_cnt = 0; tmo_at = 0;
      full = 1'b0; xfer_f = '0;
      nrst = 1'b0; fifo_full = 1'b0;
      req_valid = '0; req_data = '0; req_last = '0;

      // Reset values.
      @(negedge clk); @(negedge clk);
      chk("rst_busy",  32'(busy), 0);
      chk("rst_grant", 32'(grant_id), 0);
      chk("rst_push",  32'(fifo_push), 0);
      chk("rst_ready", 32'(req_ready), 0);
      chk("rst_tmo",   32'(tmo_err), 0);

      // Requester 2 sends "OK\n".
      do_reset();
      srcq[2].push_back(9'h04F); srcq[2].push_back(9'h04B); srcq[2].push_back(9'h10A);
      cycle();
      chk("ok_arb_push", 32'(fifo_push), 0);
      chk("ok_arb_busy", 32'(busy), 0);
      chk("ok_arb_rdy",  32'(req_ready), 0);
      cycle();
      chk("ok_grant", 32'(grant_id), 2);
      chk("ok_rdy",   32'(req_ready), 32'h4);
      chk("ok_c0",    32'(fifo_push ? fifo_data : 8'hFF), 32'h4F);
      cycle();
      chk("ok_c1",    32'(fifo_push ? fifo_data : 8'hFF), 32'h4B);
      cycle();
      chk("ok_c2",    32'(fifo_push ? fifo_data : 8'hFF), 32'h0A);
      chk("ok_busy_last", 32'(busy), 1);
      cycle();
      chk("ok_busy_drop", 32'(busy), 0);
      chk("ok_push_idle", 32'(fifo_push), 0);

      // Requesters 0 and 1 with two-character messages; no interleaving.
      do_reset();
      srcq[0].push_back(9'h0A0); srcq[0].push_back(9'h1A1);
      srcq[1].push_back(9'h0B0); srcq[1].push_back(9'h1B1);
      for (int k = 0; k < 20 && got.size() < 4; k++) cycle();
      chk("two_len", 32'(got.size()), 4);
      if (got.size() == 4) begin
         chk("two_0", 32'(got[0]), 32'hA0);
         chk("two_1", 32'(got[1]), 32'hA1);
         chk("two_2", 32'(got[2]), 32'hB0);
         chk("two_3", 32'(got[3]), 32'hB1);
      end

      // All four requesters, one-character messages: grants 0,1,2,3,0.
      do_reset();
      for (int i = 0; i < 4; i++)
         for (int m = 0; m < 3; m++) srcq[i].push_back(9'h100 | 9'(i*16 + m));
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("rr_idle_busy", 32'(busy), 0);
         cycle();
         chk("rr_grant", 32'(grant_id), 32'(k % 4));
         chk("rr_push",  32'(fifo_push), 1);
      end

      // FIFO full for five cycles mid-message.
      do_reset();
      srcq[1].push_back(9'h057); srcq[1].push_back(9'h058);
      srcq[1].push_back(9'h059); srcq[1].push_back(9'h15A);
      cycle(); cycle(); cycle();
      full = 1'b1;
      for (int k = 0; k < 5; k++) begin
         cycle();
         chk("full_push",  32'(fifo_push), 0);
         chk("full_ready", 32'(req_ready), 0);
         chk("full_busy",  32'(busy), 1);
      end
      full = 1'b0;
      for (int k = 0; k < 20 && got.size() < 4; k++) cycle();
      chk("full_len", 32'(got.size()), 4);
      if (got.size() == 4) begin
         chk("full_0", 32'(got[0]), 32'h57);
         chk("full_1", 32'(got[1]), 32'h58);
         chk("full_2", 32'(got[2]), 32'h59);
         chk("full_3", 32'(got[3]), 32'h5A);
      end
      chk("full_pushfull", 32'(push_when_full), 0);
      chk("full_tmo",      32'(tmo_cnt), 0);

      // Timeout: requester 0 goes quiet without last; requester 3 waits.
      do_reset();
      t0 = cyc;
      srcq[0].push_back(9'h0C0); srcq[0].push_back(9'h0C1);
      srcq[3].push_back(9'h1D0);
      for (int k = 0; k < 13; k++) cycle();
      chk("tmo_none_early", 32'(tmo_cnt), 0);
      chk("tmo_still_busy", 32'(busy), 1);
      cycle();
      chk("tmo_pulse", 32'(tmo_err), 1);
      chk("tmo_at",    32'(tmo_at - t0), 14);
      cycle();
      chk("tmo_idle_busy",  32'(busy), 0);
      chk("tmo_idle_pulse", 32'(tmo_err), 0);
      cycle();
      chk("tmo_next_grant", 32'(grant_id), 3);
      chk("tmo_next_data",  32'(fifo_push ? fifo_data : 8'hFF), 32'hD0);
      chk("tmo_once",       32'(tmo_cnt), 1);

      // Reset on the 2nd of 4 characters; requester 0 has priority afterwards.
      do_reset();
      srcq[0].push_back(9'h150);
      srcq[1].push_back(9'h051); srcq[1].push_back(9'h052);
      srcq[1].push_back(9'h053); srcq[1].push_back(9'h154);
      cycle(); cycle(); cycle(); cycle();
      srcq[0].push_back(9'h155);
      drive_cyc();
      #2;
      chk("mrst_pre_push", 32'(fifo_push ? fifo_data : 8'hFF), 32'h52);
      nrst = 1'b0;
      #1;
      chk("mrst_push",  32'(fifo_push), 0);
      chk("mrst_ready", 32'(req_ready), 0);
      chk("mrst_busy",  32'(busy), 0);
      chk("mrst_grant", 32'(grant_id), 0);
      chk("mrst_tmo",   32'(tmo_err), 0);
      xfer_f = '0;
      drive_cyc();
      nrst = 1'b1;
      #4;
      sample_cyc();
      cycle();
      chk("mrst_prio_grant", 32'(grant_id), 0);
      chk("mrst_prio_data",  32'(fifo_push ? fifo_data : 8'hFF), 32'h55);
      for (int k = 0; k < 20 && got.size() < 6; k++) cycle();
      chk("mrst_len", 32'(got.size()), 6);
      if (got.size() == 6) begin
         chk("mrst_0", 32'(got[0]), 32'h50);
         chk("mrst_1", 32'(got[1]), 32'h51);
         chk("mrst_2", 32'(got[2]), 32'h55);
         chk("mrst_3", 32'(got[3]), 32'h52);
         chk("mrst_4", 32'(got[4]), 32'h53);
         chk("mrst_5", 32'(got[5]), 32'h54);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/print_arb.md
PRINT_ARB -- requirements
Module: print_arb

Interface
REQ-001 SHALL have parameter NREQ, default 4, meaning number of requesters (2..8).
REQ-002 SHALL have parameter DATA_WID, default 8, meaning character width.
REQ-003 SHALL have parameter TMO_CYC, default 255, meaning idle-valid cycles before a lock is forcibly released.
REQ-004 SHALL have port clk  input  1  system clock; all state changes on its rising edge.
REQ-005 SHALL have port nrst  input  1  reset; asynchronous assertion, active-low.
REQ-006 SHALL have port req_valid  input  NREQ  per-requester character-available flag.
REQ-007 SHALL have port req_data  input  NREQ*DATA_WID  per-requester character; requester i occupies bits [i*DATA_WID +: DATA_WID].
REQ-008 SHALL have port req_last  input  NREQ  per-requester end-of-message flag, qualified by req_valid.
REQ-009 SHALL have port req_ready  output  NREQ  per-requester accept; a character transfers when valid and ready are both high on a clock edge.
REQ-010 SHALL have port fifo_push  output  1  push strobe to the character FIFO.
REQ-011 SHALL have port fifo_data  output  DATA_WID  character to the FIFO.
REQ-012 SHALL have port fifo_full  input  1  FIFO full flag.
REQ-013 SHALL have port busy  output  1  high while a requester holds the lock.
REQ-014 SHALL have port grant_id  output  3  index of the locked requester; holds its last value when not busy.
REQ-015 SHALL have port tmo_err  output  1  one-cycle pulse when a lock is released by timeout.

Function
REQ-016 SHALL implement two states: IDLE and LOCK.
REQ-017 IDLE: if any req_valid is high, SHALL register the round-robin winner into grant_id and enter LOCK next cycle; 1-cycle arbitration latency, no transfer in IDLE.
REQ-018 Round-robin search SHALL start at (last_id+1) mod NREQ and wrap, where last_id is the previously locked requester; last_id resets to NREQ-1 so requester 0 wins first.
REQ-019 LOCK: req_ready[grant_id] SHALL equal !fifo_full; all other req_ready bits SHALL be 0.
REQ-020 LOCK: fifo_push SHALL equal req_valid[grant_id] && !fifo_full; fifo_data SHALL equal req_data[grant_id] (combinational, zero latency).
REQ-021 fifo_push SHALL never assert while fifo_full is high.
REQ-022 A transfer with req_last high SHALL update last_id to grant_id and return to IDLE next cycle.
REQ-023 The lock SHALL NOT be released on any condition other than last-transfer or timeout; other requesters' valid SHALL be ignored while locked.
REQ-024 An 8-bit idle counter SHALL clear on every transfer and on LOCK entry, and SHALL increment each LOCK cycle where req_valid[grant_id] is low; fifo_full stall cycles with valid high SHALL NOT count.
REQ-025 When the idle counter reaches TMO_CYC, SHALL pulse tmo_err, update last_id to grant_id and return to IDLE.
REQ-026 Last-transfer and timeout in the same cycle SHALL be treated as a normal last-transfer with no tmo_err.
REQ-027 In IDLE: fifo_push, all req_ready bits and tmo_err SHALL be 0.

Reset
REQ-028 nrst low SHALL immediately force IDLE, grant_id=0, last_id=NREQ-1, idle counter=0, busy=0, tmo_err=0, fifo_push=0, req_ready=0.
REQ-029 Reset mid-message SHALL drop the lock with no further push; characters already pushed remain in the FIFO.
REQ-030 Reset removal SHALL be synchronous to clk.

Structure
REQ-031 A shared print_pkg SHALL hold the state enum, DATA_WID default and the timeout-counter width.
REQ-032 The round-robin search SHALL be one combinational sub-module, rr_pick (inputs: request vector, last_id; output: winner index, any).

Verification
REQ-033 Requester 2 only sends "OK\n" with last on '\n': 1 idle cycle, then pushes 0x4F, 0x4B, 0x0A on consecutive cycles; busy drops the cycle after 0x0A.
REQ-034 Requesters 0 and 1 each hold a 2-character message at reset release: the FIFO receives all of requester 0's message, then requester 1's; there is no interleaving.
REQ-035 All 4 requesters send 1-character messages continuously: grants cycle 0,1,2,3,0 with each grant 2 cycles apart.
REQ-036 fifo_full is held high 5 cycles mid-message: there is no push and no tmo_err, and the message resumes intact.
REQ-037 With TMO_CYC=10, the locked requester drops valid with no last: tmo_err pulses once 10 cycles later, and a waiting requester is granted next.
REQ-038 nrst is asserted on the 2nd of 4 characters: outputs go to 0 within the same cycle, and after release requester 0 has priority.
